// File: rtl/fifo_wr_arbiter.sv
// Write-side arbiter for the dual-clock FIFO: round-robin grant, locked per burst,
// each beat written as {source_id, payload} so the read side can demultiplex.
`timescale 1ns/1ps
module fifo_wr_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int PAYLOAD_WIDTH = 6,
  parameter int ID_WIDTH      = $clog2(NUM_REQ),
  parameter int MAX_BURST     = 8,
  parameter int IDLE_TIMEOUT  = 4
) (
  input  logic                               w_clk,
  input  logic                               w_rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  input  logic [NUM_REQ*PAYLOAD_WIDTH-1:0]   req_data,
  input  logic [NUM_REQ-1:0]                 req_last,
  output logic [NUM_REQ-1:0]                 req_ready,
  output logic                               fifo_w_inc,
  output logic [ID_WIDTH+PAYLOAD_WIDTH-1:0]  fifo_w_data,
  input  logic                               fifo_w_full,
  output logic [ID_WIDTH-1:0]                grant_id,
  output logic                               busy
);

  localparam int BEAT_W = $clog2(MAX_BURST + 1);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [BEAT_W-1:0]   MAX_BEATS  = BEAT_W'(MAX_BURST);
  localparam logic [IDLE_W-1:0]   IDLE_LIMIT = IDLE_W'(IDLE_TIMEOUT);
  localparam logic [ID_WIDTH-1:0] LAST_ID    = ID_WIDTH'(NUM_REQ - 1);

  typedef enum logic {
    S_IDLE,
    S_BURST
  } state_e;

  state_e              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
  logic [ID_WIDTH-1:0] grant_id_q, grant_id_d;
  logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;

  logic [ID_WIDTH-1:0]      pick;
  logic                     pick_vld;
  int                       best_off;
  int                       off;
  logic                     sel_valid;
  logic                     sel_last;
  logic [PAYLOAD_WIDTH-1:0] sel_data;
  logic                     xfer;
  logic                     end_burst;

  // Round-robin pick: the valid requester at the smallest distance above rr_ptr wins.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    best_off = NUM_REQ;
    off      = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      off = i - int'(rr_ptr_q);
      if (off < 0) off = off + NUM_REQ;
      if (req_valid[i] && (off < best_off)) begin
        best_off = off;
        pick     = ID_WIDTH'(i);
        pick_vld = 1'b1;
      end
    end
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id_q == ID_WIDTH'(i)) begin
        sel_valid = req_valid[i];
        sel_last  = req_last[i];
        sel_data  = req_data[i*PAYLOAD_WIDTH +: PAYLOAD_WIDTH];
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    grant_id_d  = grant_id_q;
    beat_cnt_d  = beat_cnt_q;
    idle_cnt_d  = idle_cnt_q;
    req_ready   = '0;
    fifo_w_inc  = 1'b0;
    fifo_w_data = '0;
    xfer        = 1'b0;
    end_burst   = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_vld) begin
          grant_id_d = pick;
          beat_cnt_d = '0;
          idle_cnt_d = '0;
          state_d    = S_BURST;
        end
      end

      S_BURST: begin
        for (int i = 0; i < NUM_REQ; i++) begin
          req_ready[i] = (grant_id_q == ID_WIDTH'(i)) && !fifo_w_full;
        end
        xfer = sel_valid && !fifo_w_full;
        if (xfer) begin
          fifo_w_inc  = 1'b1;
          fifo_w_data = {grant_id_q, sel_data};
          beat_cnt_d  = beat_cnt_q + 1'b1;
          idle_cnt_d  = '0;
          end_burst   = sel_last || (beat_cnt_d == MAX_BEATS);
        end else if (!sel_valid) begin
          idle_cnt_d = idle_cnt_q + 1'b1;
          end_burst  = (idle_cnt_d == IDLE_LIMIT);
        end else begin
          // Valid but stalled by a full FIFO: the requester is not idle.
          idle_cnt_d = '0;
        end
        if (end_burst) begin
          state_d  = S_IDLE;
          rr_ptr_d = (grant_id_q == LAST_ID) ? '0 : grant_id_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: registers take non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge w_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      state_q    <= S_IDLE;
      rr_ptr_q   <= '0;
      grant_id_q <= '0;
      beat_cnt_q <= '0;
      idle_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_id_q <= grant_id_d;
      beat_cnt_q <= beat_cnt_d;
      idle_cnt_q <= idle_cnt_d;
    end
  end

  assign grant_id = grant_id_q;
  assign busy     = (state_q == S_BURST);

endmodule
